// File: rtl/router_sync_param.sv
// Header-address router for NUM_CH FIFOs. It latches the destination address,
// steers the upstream write strobe, and runs a per-channel unread-data watchdog.
//
// Handshake: a write is issued to channel addr_q only while wr_en_reg is high
// and that FIFO is not full. A channel's data is consumed when rd_en[i] is high
// while vld_out[i] (= ~empty[i]) is high. There is no backpressure beyond full[].
module router_sync_param #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] din,
  input  logic              detect_addr,
  input  logic              wr_en_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] rd_en,
  input  logic              timeout_en,
  output logic [NUM_CH-1:0] wr_en,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT - 1);
  // One extra bit so the range compare also works when NUM_CH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   NUM_CH_X = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_q;
  logic              addr_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      addr_err <= 1'b0;
    end else if (detect_addr) begin
      addr_q   <= din;
      addr_err <= ({1'b0, din} >= NUM_CH_X);
    end
  end

  assign addr_ok = ({1'b0, addr_q} < NUM_CH_X);

  // Steering uses the registered address, so a same-cycle detect_addr does not
  // redirect the write already in flight.
  always_comb begin
    wr_en     = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_ok && (addr_q == ADDR_W'(i))) begin
        wr_en[i]  = wr_en_reg & ~full[i];
        fifo_full = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_wdog
    logic [CNT_W-1:0] cnt;
    logic             pulse;

    // Counter restarts whenever the channel is idle, drained or the watchdog
    // is off; at the terminal count it fires once and starts a fresh period.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt   <= '0;
        pulse <= 1'b0;
      end else if (!timeout_en || !vld_out[g] || rd_en[g]) begin
        cnt   <= '0;
        pulse <= 1'b0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        pulse <= 1'b1;
      end else begin
        cnt   <= cnt + 1'b1;
        pulse <= 1'b0;
      end
    end

    assign soft_reset[g] = pulse;
  end

endmodule
